// File: rtl/a2d_arb_pkg.sv
// ---------------------------------------------------------------------------
// a2d_arb_pkg
// Shared types and constants for the A2D arbiter.
//   state_t        : arbiter FSM states
//   CHNNL_*        : A2D channel numbers of the IR sensor pairs
//   GAP_CYC_DEF    : default settle gap between conversions (cycles)
//   TMO_CYC_DEF    : default cnv_cmplt timeout (cycles)
// ---------------------------------------------------------------------------
package a2d_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } state_t;

   // IR sensor channel map on the shared A2D (left/right of each pair)
   localparam logic [2:0] CHNNL_IR_IN_L  = 3'd1;
   localparam logic [2:0] CHNNL_IR_IN_R  = 3'd0;
   localparam logic [2:0] CHNNL_IR_MID_L = 3'd4;
   localparam logic [2:0] CHNNL_IR_MID_R = 3'd2;
   localparam logic [2:0] CHNNL_IR_OUT_L = 3'd3;
   localparam logic [2:0] CHNNL_IR_OUT_R = 3'd7;

   localparam int GAP_CYC_DEF = 32;
   localparam int TMO_CYC_DEF = 4096;

endpackage

// File: rtl/a2d_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector.
//   req   in  NREQ  pending requests
//   ptr   in  PW    index of the last requester served
//   found out 1     at least one request pending
//   idx   out PW    winner: first set req bit at ptr+1, ptr+2, ... mod NREQ
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 3,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            found,
   output logic [PW-1:0]   idx
);

   logic [PW-1:0] cand;

   // Walk the offsets from farthest to nearest so the requester closest
   // after ptr is written last and therefore wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int off = NREQ; off >= 1; off--) begin
         cand = PW'((int'(ptr) + off) % NREQ);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/a2d_arb.sv
// ---------------------------------------------------------------------------
// a2d_arb
// Round-robin arbiter sharing one A2D converter among NREQ requesters.
// One conversion per grant, result returned with a one-cycle ack, then a
// settle gap; a timeout aborts a conversion whose cnv_cmplt never arrives.
//   clk, rst   : clock, synchronous active-high reset
//   req        : level requests, held until ack
//   req_chnnl  : 3-bit channel per requester at [3i+2:3i]
//   ack        : one-cycle pulse to the granted requester
//   res, tmo   : result / timeout flag, valid with ack
//   busy       : high whenever not idle
//   strt_cnv   : one-cycle start pulse to the A2D
//   chnnl      : channel to the A2D, held through the conversion
//   cnv_cmplt  : A2D done pulse, A2D_res valid with it
// ---------------------------------------------------------------------------
module a2d_arb
   import a2d_arb_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int GAP_CYC = GAP_CYC_DEF,
   parameter int TMO_CYC = TMO_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] req_chnnl,
   output logic [NREQ-1:0]   ack,
   output logic [11:0]       res,
   output logic              tmo,
   output logic              busy,
   output logic              strt_cnv,
   output logic [2:0]        chnnl,
   input  logic              cnv_cmplt,
   input  logic [11:0]       A2D_res
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2((TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC);

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     gnt_q, gnt_d;
   logic [2:0]        chnnl_q, chnnl_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              tmo_q, tmo_d;
   logic [11:0]       res_q, res_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic              pick_found;
   logic [PW-1:0]     pick_idx;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Next-state logic. The single down-counter serves both the timeout
   // (loaded with TMO_CYC-2 in START so the terminal count lands on the
   // last WAIT cycle) and the settle gap (loaded with GAP_CYC-1 on leaving
   // WAIT so GAP lasts exactly GAP_CYC cycles). cnv_cmplt is tested before
   // the terminal count so a completion on that cycle still wins.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      chnnl_d = chnnl_q;
      ack_d   = '0;
      tmo_d   = 1'b0;
      res_d   = res_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               gnt_d = pick_idx;
               for (int i = 0; i < NREQ; i++) begin
                  if (pick_idx == PW'(i)) begin
                     chnnl_d = req_chnnl[3*i +: 3];
                  end
               end
               state_d = START;
            end
         end
         START: begin
            cnt_d   = CW'(TMO_CYC - 2);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnv_cmplt) begin
               res_d        = A2D_res;
               ack_d[gnt_q] = 1'b1;
               tmo_d        = 1'b0;
               ptr_d        = gnt_q;
               cnt_d        = CW'(GAP_CYC - 1);
               state_d      = GAP;
            end else if (cnt_q == '0) begin
               res_d        = 12'h000;
               ack_d[gnt_q] = 1'b1;
               tmo_d        = 1'b1;
               ptr_d        = gnt_q;
               cnt_d        = CW'(GAP_CYC - 1);
               state_d      = GAP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. The pointer resets to the last
   // requester so requester 0 is the first one searched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= PW'(NREQ - 1);
         gnt_q   <= '0;
         chnnl_q <= '0;
         ack_q   <= '0;
         tmo_q   <= 1'b0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         chnnl_q <= chnnl_d;
         ack_q   <= ack_d;
         tmo_q   <= tmo_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ack      = ack_q;
   assign tmo      = tmo_q;
   assign res      = res_q;
   assign chnnl    = chnnl_q;
   assign busy     = (state_q != IDLE);
   assign strt_cnv = (state_q == START);

endmodule

// File: doc/a2d_arb.md
# a2d_arb

Shares the single A2D interface (strt_cnv / chnnl / cnv_cmplt / A2D_res) among up to four requesters, e.g. motion control, battery monitor and diagnostics. Each requester presents a level request and a channel. The block grants requesters round-robin and runs exactly one conversion per grant. It then returns the 12-bit result with a one-cycle ack and enforces a settle gap before the next conversion. A timeout prevents a missing cnv_cmplt from hanging the bus.

## Interface
- NREQ, 3, number of requesters (2..4)
- GAP_CYC, 32, idle cycles between conversions (≥1)
- TMO_CYC, 4096, cycles to wait for cnv_cmplt before aborting (≥2)

- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- req  in  NREQ  level request, bit i = requester i; held until ack[i]
- req_chnnl  in  3*NREQ  channel of requester i at [3i+2:3i]
- ack  out  NREQ  one-cycle pulse to the granted requester; res and tmo valid that cycle
- res  out  12  result of last completed conversion
- tmo  out  1  pulses with ack when the conversion timed out
- busy  out  1  high in every state except IDLE
- strt_cnv  out  1  one-cycle start pulse to A2D
- chnnl  out  3  channel to A2D; stable from strt_cnv until the conversion ends
- cnv_cmplt  in  1  A2D done pulse
- A2D_res  in  12  A2D result, valid while cnv_cmplt is high

## Operation
- States: IDLE, START, WAIT, GAP.
- IDLE: if |req, pick the winner with a round-robin search starting at ptr+1 and wrapping modulo NREQ. Latch gnt index and chnnl <= req_chnnl[gnt]. Go to START. With no request, stay in IDLE.
- START: strt_cnv=1 for this single cycle. Clear the timeout counter. Go to WAIT.
- WAIT, cnv_cmplt=1: res <= A2D_res, ack[gnt] <= 1, tmo <= 0, ptr <= gnt. Go to GAP.
- WAIT, counter reaches TMO_CYC-1 without cnv_cmplt: res <= 12'h000, ack[gnt] <= 1, tmo <= 1, ptr <= gnt. Go to GAP.
- cnv_cmplt and timeout terminal count in the same cycle: the cnv_cmplt case wins.
- GAP: count GAP_CYC cycles, then go to IDLE. ack and tmo are high only in the first GAP cycle.
- cnv_cmplt while in IDLE, START or GAP is ignored.
- A requester dropping req during START or WAIT does not abort the conversion; its ack is still issued and the requester may ignore it.
- A requester must deassert req the cycle after ack, or it is eligible for re-grant. Because of round-robin it still yields to any other pending requester.
- Out-of-range index bits above NREQ-1 never win.

## Timing
- Reset values: state=IDLE, ptr=NREQ-1 (requester 0 wins first), strt_cnv=0, chnnl=0, ack=0, tmo=0, res=0, busy=0, counters=0.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- req rises in cycle 0 with the block in IDLE → strt_cnv=1 and chnnl valid in cycle 1 → WAIT from cycle 2.
- cnv_cmplt high in cycle k → ack/res valid in cycle k+1 → IDLE in cycle k+1+GAP_CYC. The next strt_cnv can come at cycle k+2+GAP_CYC at the earliest.
- Timeout: ack/tmo appear TMO_CYC cycles after the strt_cnv cycle.
- rst asserted in any state: at the next edge, state=IDLE, outputs go to reset values, and any in-flight conversion is discarded with no ack. The pointer also resets.

## Structure
- Package a2d_arb_pkg: state enum type; A2D channel constants (IR inner 1/0, middle 4/2, outer 3/7); the default GAP_CYC and TMO_CYC values.
- Sub-module rr_pick: combinational round-robin selector. Inputs req[NREQ-1:0] and ptr. Outputs found and idx.
- Single shared down-counter in the top level for both GAP and timeout, sized to clog2(TMO_CYC).

## Test plan
- Single request: req=3'b001, req_chnnl[2:0]=3'd4, A2D returns 12'hA5C three cycles after strt_cnv → chnnl=4, exactly one strt_cnv pulse, ack=3'b001 with res=12'hA5C, tmo=0.
- Fairness: req=3'b111 held and each re-asserted after ack → grant order 0,1,2,0,1,2, with at least GAP_CYC cycles between strt_cnv pulses.
- Timeout: cnv_cmplt never asserted → ack pulses exactly TMO_CYC cycles after strt_cnv with tmo=1 and res=12'h000; the next request is served normally.
- Collision and stray events: cnv_cmplt on the timeout terminal cycle → tmo=0 and res=A2D_res. A cnv_cmplt pulse during GAP produces no ack.
- Reset mid-WAIT: rst for one cycle, then a late cnv_cmplt → no ack; next grant goes to requester 0; the state/outputs match reset values.
- Requester dropping req in WAIT → ack still issued; next grant skips that requester when its req=0.
